// File: rtl/lsmitll_nott_bank_if.sv
// lsmitll_nott_bank_if: pulse bus of the NOTT bank; viol_cnt exists only with NOTT_VIOL_COUNT_EN
interface lsmitll_nott_bank_if #(parameter int N = 4);
  logic [N-1:0] a;
  logic [N-1:0] q;
  logic [N-1:0] viol;
  logic ck;
  logic ready;
  logic viol_ck;
`ifdef NOTT_VIOL_COUNT_EN
  logic [15:0] viol_cnt;
  modport master (output a, ck, input q, ready, viol, viol_ck, viol_cnt);
  modport slave (input a, ck, output q, ready, viol, viol_ck, viol_cnt);
`else
  modport master (output a, ck, input q, ready, viol, viol_ck);
  modport slave (input a, ck, output q, ready, viol, viol_ck);
`endif
endinterface

// File: rtl/lsmitll_nott_bank.sv
// lsmitll_nott_bank: N-channel clocked inverter / DFF bank with hold checks; NOTT_VIOL_COUNT_EN adds viol_cnt
module lsmitll_nott_bank #(
  parameter int N = 4,
  parameter int MODE = 0,
  parameter int DELAY_CYC = 2,
  parameter int INIT_CYC = 8,
  parameter int HOLD_A_CK = 3,
  parameter int HOLD_CK_A = 2,
  parameter int HOLD_CK_CK = 4
) (
  input logic clk,
  input logic rst_n,
  lsmitll_nott_bank_if.slave bus
);
  localparam int HMAX = (HOLD_A_CK > HOLD_CK_A) ? ((HOLD_A_CK > HOLD_CK_CK) ? HOLD_A_CK : HOLD_CK_CK)
                                               : ((HOLD_CK_A > HOLD_CK_CK) ? HOLD_CK_A : HOLD_CK_CK);
  localparam int W = $clog2(HMAX + 1);
  localparam int IW = $clog2(INIT_CYC + 1);
  localparam logic [W-1:0] H_A_CK = W'(HOLD_A_CK);
  localparam logic [W-1:0] H_CK_A = W'(HOLD_CK_A);
  localparam logic [W-1:0] H_CK_CK = W'(HOLD_CK_CK);
  localparam logic [IW-1:0] INIT_END = IW'(INIT_CYC);
  typedef enum logic {EMPTY, LOADED} state_t;
  state_t r_st [N];
  state_t w_st_nx [N];
  logic [N-1:0] r_a_d;
  logic [N-1:0] r_q;
  logic [N-1:0] r_viol;
  logic [N-1:0] w_a_p;
  logic [N-1:0] w_a_eff;
  logic [N-1:0] w_emit;
  logic [N-1:0] w_viol;
  logic [N-1:0] r_pipe [DELAY_CYC];
  logic [W-1:0] r_since_a [N];
  logic [W-1:0] r_since_ck;
  logic [IW-1:0] r_init;
  logic r_ck_d;
  logic r_viol_ck;
  logic w_ready;
  logic w_ck_p;
  logic w_viol_ck;
  assign w_ready = r_init == INIT_END;
  assign w_a_p = w_ready ? (bus.a ^ r_a_d) : '0;
  assign w_ck_p = w_ready & (bus.ck ^ r_ck_d);
  assign w_viol_ck = w_ck_p & (r_since_ck < H_CK_CK);
  always_ff @(posedge clk) begin
    if (!rst_n) r_st <= '{default: EMPTY};
    else r_st <= w_st_nx;
  end
  // ck acts on the pre-state; a data pulse on a LOADED channel only counts when ck empties it that cycle
  always_comb begin
    w_emit = '0;
    w_a_eff = '0;
    w_viol = '0;
    w_st_nx = r_st;
    for (int i = 0; i < N; i++) begin
      w_emit[i] = w_ck_p & ((MODE != 0) == (r_st[i] == LOADED));
      w_a_eff[i] = w_a_p[i] & ((r_st[i] == EMPTY) | w_ck_p);
      w_st_nx[i] = w_a_eff[i] ? LOADED : (w_ck_p ? EMPTY : r_st[i]);
      w_viol[i] = (w_a_eff[i] & (w_ck_p | (r_since_ck < H_CK_A)))
                | (w_ck_p & (r_st[i] == LOADED) & (r_since_a[i] < H_A_CK));
    end
  end
  always_ff @(posedge clk) begin
    r_a_d <= bus.a;
    r_ck_d <= bus.ck;
    if (!rst_n) begin
      r_init <= '0;
      r_q <= '0;
      r_viol <= '0;
      r_viol_ck <= '0;
      r_pipe <= '{default: '0};
      r_since_a <= '{default: '1};
      r_since_ck <= '1;
    end else begin
      r_init <= w_ready ? r_init : r_init + IW'(1);
      r_q <= r_q ^ r_pipe[DELAY_CYC-1];
      r_viol <= w_viol;
      r_viol_ck <= w_viol_ck;
      r_pipe[0] <= w_emit;
      for (int k = 1; k < DELAY_CYC; k++) r_pipe[k] <= r_pipe[k-1];
      r_since_ck <= w_ck_p ? '0 : r_since_ck + W'(r_since_ck != '1);
      for (int i = 0; i < N; i++) r_since_a[i] <= w_a_eff[i] ? '0 : r_since_a[i] + W'(r_since_a[i] != '1);
    end
  end
  assign bus.q = r_q;
  assign bus.ready = w_ready;
  assign bus.viol = r_viol;
  assign bus.viol_ck = r_viol_ck;
`ifdef NOTT_VIOL_COUNT_EN
  logic [15:0] r_cnt;
  logic [16:0] w_sum;
  always_comb begin
    w_sum = {1'b0, r_cnt} + 17'(w_viol_ck);
    for (int i = 0; i < N; i++) w_sum = w_sum + 17'(w_viol[i]);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) r_cnt <= '0;
    else r_cnt <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
  end
  assign bus.viol_cnt = r_cnt;
`endif
endmodule

// File: tb/tb_lsmitll_nott_bank.sv
// tb_lsmitll_nott_bank: NOT-mode and DFF-mode banks on shared stimulus, q checked through a toggle scoreboard
module tb_lsmitll_nott_bank;
  localparam int D = 2;
  typedef struct {
    int due;
    logic [3:0] m0;
    logic [3:0] m1;
  } sb_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_seen = 1'b0;
  logic [3:0] a = '0;
  logic ck = 1'b0;
  logic [3:0] ld = '0;
  logic [3:0] eq0 = '0;
  logic [3:0] eq1 = '0;
  int n = 0;
  int errors = 0;
  int checks = 0;
  sb_t sb [$];
  lsmitll_nott_bank_if #(.N(4)) bus0 ();
  lsmitll_nott_bank_if #(.N(4)) bus1 ();
  assign bus0.a = a;
  assign bus0.ck = ck;
  assign bus1.a = a;
  assign bus1.ck = ck;
  lsmitll_nott_bank #(.N(4), .MODE(0), .DELAY_CYC(D)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  lsmitll_nott_bank #(.N(4), .MODE(1), .DELAY_CYC(D)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    n <= n + 1;
    rst_seen <= rst_n;
  end
  // Applied at a negedge; the following posedge samples it, so q toggles are due D+1 negedges later
  task automatic drive(input logic [3:0] am, input logic ckp);
    a = a ^ am;
    ck = ck ^ ckp;
    if (ckp) sb.push_back('{n + D + 1, ~ld, ld});
    ld = ckp ? am : (ld | am);
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    ld = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus0.q !== 4'b0 || bus1.q !== 4'b0) begin
      errors++;
      $display("FAIL reset_q got %b/%b want 0000", bus0.q, bus1.q);
    end
    checks++;
    if (bus0.ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got %b want 0", bus0.ready);
    end
    checks++;
    if (bus0.viol !== 4'b0 || bus0.viol_ck !== 1'b0) begin
      errors++;
      $display("FAIL reset_viol got %b/%b want 0000/0", bus0.viol, bus0.viol_ck);
    end
`ifdef NOTT_VIOL_COUNT_EN
    checks++;
    if (bus0.viol_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt got %0d want 0", bus0.viol_cnt);
    end
`endif
    rst_n = 1'b1;
  endtask
  task automatic test_init_window();
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      checks++;
      if (bus0.ready !== (k >= 8) || bus1.ready !== (k >= 8)) begin
        errors++;
        $display("FAIL init_ready k=%0d got %b/%b want %b", k, bus0.ready, bus1.ready, k >= 8);
      end
      checks++;
      if (bus0.viol !== 4'b0 || bus0.viol_ck !== 1'b0) begin
        errors++;
        $display("FAIL init_viol k=%0d got %b/%b want 0000/0", k, bus0.viol, bus0.viol_ck);
      end
      if (k == 2) a = a ^ 4'b1111;
      if (k == 3 || k == 4) ck = ~ck;
      if (k == 7) begin
        a = a ^ 4'b0001;
        ck = ~ck;
      end
    end
  endtask
  task automatic test_not_dff();
    drive(4'b0101, 1'b0);
    repeat (5) @(negedge clk);
    drive(4'b0000, 1'b1);
    @(negedge clk);
    checks++;
    if (bus0.viol !== 4'b0 || bus0.viol_ck !== 1'b0) begin
      errors++;
      $display("FAIL nd_viol got %b/%b want 0000/0", bus0.viol, bus0.viol_ck);
    end
    @(negedge clk);
    checks++;
    if (bus0.q !== 4'b0000 || bus1.q !== 4'b0000) begin
      errors++;
      $display("FAIL nd_early got %b/%b want 0000/0000", bus0.q, bus1.q);
    end
    @(negedge clk);
    checks++;
    if (bus0.q !== 4'b1010 || bus1.q !== 4'b0101) begin
      errors++;
      $display("FAIL nd_first got %b/%b want 1010/0101", bus0.q, bus1.q);
    end
    repeat (3) @(negedge clk);
    drive(4'b0000, 1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if (bus0.q !== 4'b0101 || bus1.q !== 4'b0101) begin
      errors++;
      $display("FAIL nd_second got %b/%b want 0101/0101", bus0.q, bus1.q);
    end
  endtask
  task automatic test_hold();
    repeat (8) @(negedge clk);
    drive(4'b0001, 1'b0);
    @(negedge clk);
    checks++;
    if (bus0.viol !== 4'b0) begin
      errors++;
      $display("FAIL hold_a got %b want 0000", bus0.viol);
    end
    drive(4'b0000, 1'b1);
    @(negedge clk);
    checks++;
    if (bus0.viol !== 4'b0001 || bus1.viol !== 4'b0001 || bus0.viol_ck !== 1'b0) begin
      errors++;
      $display("FAIL hold_a_ck got %b/%b/%b want 0001/0001/0", bus0.viol, bus1.viol, bus0.viol_ck);
    end
    drive(4'b0000, 1'b1);
    @(negedge clk);
    checks++;
    if (bus0.viol_ck !== 1'b1 || bus0.viol !== 4'b0) begin
      errors++;
      $display("FAIL hold_ck_ck got %b/%b want 1/0000", bus0.viol_ck, bus0.viol);
    end
    drive(4'b0010, 1'b0);
    @(negedge clk);
    checks++;
    if (bus0.viol !== 4'b0010 || bus1.viol_ck !== 1'b0) begin
      errors++;
      $display("FAIL hold_ck_a got %b/%b want 0010/0", bus0.viol, bus1.viol_ck);
    end
`ifdef NOTT_VIOL_COUNT_EN
    checks++;
    if (bus0.viol_cnt !== 16'd3) begin
      errors++;
      $display("FAIL hold_cnt got %0d want 3", bus0.viol_cnt);
    end
`endif
  endtask
  task automatic test_same_cycle();
    repeat (8) @(negedge clk);
    drive(4'b0001, 1'b1);
    @(negedge clk);
    checks++;
    if (bus0.viol !== 4'b0001 || bus1.viol !== 4'b0001 || bus0.viol_ck !== 1'b0) begin
      errors++;
      $display("FAIL same_viol got %b/%b/%b want 0001/0001/0", bus0.viol, bus1.viol, bus0.viol_ck);
    end
    repeat (7) @(negedge clk);
    drive(4'b0000, 1'b1);
    @(negedge clk);
    checks++;
    if (bus0.viol !== 4'b0 || bus0.viol_ck !== 1'b0) begin
      errors++;
      $display("FAIL same_later got %b/%b want 0000/0", bus0.viol, bus0.viol_ck);
    end
    repeat (3) @(negedge clk);
  endtask
  task automatic test_back_to_back();
    repeat (8) @(negedge clk);
    drive(4'b0000, 1'b1);
    @(negedge clk);
    checks++;
    if (bus0.viol_ck !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first got %b want 0", bus0.viol_ck);
    end
    drive(4'b0000, 1'b1);
    @(negedge clk);
    checks++;
    if (bus0.viol_ck !== 1'b1 || bus0.viol !== 4'b0) begin
      errors++;
      $display("FAIL b2b_second got %b/%b want 1/0000", bus0.viol_ck, bus0.viol);
    end
    @(negedge clk);
    checks++;
    if (bus0.viol_ck !== 1'b0) begin
      errors++;
      $display("FAIL b2b_pulse got %b want 0", bus0.viol_ck);
    end
    repeat (3) @(negedge clk);
  endtask
  task automatic test_reset_midflight();
    repeat (8) @(negedge clk);
    drive(4'b0000, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ld = '0;
    checks++;
    if (bus0.q !== 4'b0 || bus1.q !== 4'b0) begin
      errors++;
      $display("FAIL mid_reset_q got %b/%b want 0000", bus0.q, bus1.q);
    end
`ifdef NOTT_VIOL_COUNT_EN
    checks++;
    if (bus0.viol_cnt !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset_cnt got %0d want 0", bus0.viol_cnt);
    end
`endif
    @(negedge clk);
    checks++;
    if (bus0.q !== 4'b0 || bus0.ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_dropped got %b/%b want 0000/0", bus0.q, bus0.ready);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (bus0.ready !== 1'b1 || bus0.q !== 4'b0) begin
      errors++;
      $display("FAIL mid_recover got %b/%b want 1/0000", bus0.ready, bus0.q);
    end
  endtask
  initial begin
    fork
      forever begin
        @(negedge clk);
        if (!rst_seen) begin
          sb.delete();
          eq0 = '0;
          eq1 = '0;
        end
        while (sb.size() > 0 && sb[0].due == n) begin
          eq0 = eq0 ^ sb[0].m0;
          eq1 = eq1 ^ sb[0].m1;
          void'(sb.pop_front());
        end
        checks++;
        if (bus0.q !== eq0 || bus1.q !== eq1) begin
          errors++;
          $display("FAIL q_scoreboard n=%0d not=%b want %b dff=%b want %b", n, bus0.q, eq0, bus1.q, eq1);
        end
      end
    join_none
    test_reset();
    test_init_window();
    test_not_dff();
    test_hold();
    test_same_cycle();
    test_back_to_back();
    test_reset_midflight();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
